// File: rtl/ifm_rx_sort.sv
// Receive-side frame sorter: forwards good frames to the good FIFO and appends a 6-word status record, discards bad frames.
// Optional frame statistics counters are built only when IFM_RX_SORT_STATS_EN is defined.
module ifm_rx_sort #(
  parameter logic [3:0] C_STS_TAG   = 4'h5,
  parameter int         C_MAX_BYTES = 2048
) (
  input  logic        s2mm_clk,
  input  logic        sys_rst,
  input  logic        info_fifo_empty,
  input  logic [7:0]  info_fifo_rdata,
  output logic        info_fifo_rden,
  input  logic        data_fifo_empty,
  input  logic [72:0] data_fifo_rdata,
  output logic        data_fifo_rden,
  output logic [72:0] good_fifo_wdata,
  output logic        good_fifo_wren,
  input  logic        good_fifo_afull,
  output logic [36:0] ctrl_fifo_wdata,
  output logic        ctrl_fifo_wren,
  input  logic        ctrl_fifo_afull,
  output logic [31:0] good_frame_cnt,
  output logic [31:0] drop_frame_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, STS, DROP} state_t;

  // The status byte count is 16 bits wide, so larger frames cannot be reported.
  if (C_MAX_BYTES < 8 || C_MAX_BYTES > 65535) begin : g_bad_max_bytes
    $error("ifm_rx_sort: C_MAX_BYTES out of range");
  end

  state_t      state;
  logic [7:0]  info_q;
  logic [15:0] byte_cnt;
  logic [2:0]  sts_idx;
  logic [36:0] sts_word;
  logic [16:0] byte_sum;
  logic [15:0] byte_next;
  logic        data_tlast;
  logic [7:0]  data_tkeep;
  logic        sts_done;
  logic        drop_done;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  assign data_tlast = data_fifo_rdata[72];
  assign data_tkeep = data_fifo_rdata[71:64];

  // Read strobes are combinational so a FWFT word is consumed in the cycle it is accepted.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    info_fifo_rden = 1'b0;
    data_fifo_rden = 1'b0;
    if (!sys_rst) begin
      unique case (state)
        IDLE:    info_fifo_rden = !info_fifo_empty;
        FWD:     data_fifo_rden = !data_fifo_empty && !good_fifo_afull;
        DROP:    data_fifo_rden = !data_fifo_empty;
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_sum  = {1'b0, byte_cnt} + {13'b0, popcount8(data_tkeep)};
    byte_next = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
  end

  always_comb begin
    unique case (sts_idx)
      3'd0:    sts_word = {1'b0, 4'hF, C_STS_TAG, 20'h0, info_q};
      3'd5:    sts_word = {1'b1, 4'hF, 16'h0, byte_cnt};
      default: sts_word = {1'b0, 4'hF, 32'h0};
    endcase
  end

  assign sts_done  = (state == STS) && !ctrl_fifo_afull && (sts_idx == 3'd5);
  assign drop_done = (state == DROP) && data_fifo_rden && data_tlast;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s2mm_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state           <= IDLE;
      info_q          <= '0;
      byte_cnt        <= '0;
      sts_idx         <= '0;
      good_fifo_wren  <= 1'b0;
      good_fifo_wdata <= '0;
      ctrl_fifo_wren  <= 1'b0;
      ctrl_fifo_wdata <= '0;
    end else begin
      good_fifo_wren <= 1'b0;
      ctrl_fifo_wren <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!info_fifo_empty) begin
            info_q   <= info_fifo_rdata;
            byte_cnt <= '0;
            sts_idx  <= '0;
            state    <= (info_fifo_rdata[0] && !info_fifo_rdata[1]) ? FWD : DROP;
          end
        end
        FWD: begin
          if (data_fifo_rden) begin
            good_fifo_wren  <= 1'b1;
            good_fifo_wdata <= data_fifo_rdata;
            byte_cnt        <= byte_next;
            if (data_tlast) state <= STS;
          end
        end
        STS: begin
          // The index only advances on an actual write, so afull never duplicates a word.
          if (!ctrl_fifo_afull) begin
            ctrl_fifo_wren  <= 1'b1;
            ctrl_fifo_wdata <= sts_word;
            if (sts_idx == 3'd5) begin
              sts_idx <= '0;
              state   <= IDLE;
            end else begin
              sts_idx <= sts_idx + 3'd1;
            end
          end
        end
        DROP: begin
          if (drop_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFM_RX_SORT_STATS_EN
  always_ff @(posedge s2mm_clk or posedge sys_rst) begin
    if (sys_rst) begin
      good_frame_cnt <= '0;
      drop_frame_cnt <= '0;
    end else begin
      if (sts_done)  good_frame_cnt <= good_frame_cnt + 32'd1;
      if (drop_done) drop_frame_cnt <= drop_frame_cnt + 32'd1;
    end
  end
`else
  assign good_frame_cnt = 32'h0;
  assign drop_frame_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifm_rx_sort.sv
// Directed bench for ifm_rx_sort: FWFT FIFO models upstream, write loggers downstream.
module tb_ifm_rx_sort;

  logic        s2mm_clk = 1'b0;
  logic        sys_rst  = 1'b1;
  logic        info_fifo_empty;
  logic [7:0]  info_fifo_rdata;
  logic        info_fifo_rden;
  logic        data_fifo_empty;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_rden;
  logic [72:0] good_fifo_wdata;
  logic        good_fifo_wren;
  logic        good_fifo_afull = 1'b0;
  logic [36:0] ctrl_fifo_wdata;
  logic        ctrl_fifo_wren;
  logic        ctrl_fifo_afull = 1'b0;
  logic [31:0] good_frame_cnt;
  logic [31:0] drop_frame_cnt;

  ifm_rx_sort dut (
    .s2mm_clk        (s2mm_clk),
    .sys_rst         (sys_rst),
    .info_fifo_empty (info_fifo_empty),
    .info_fifo_rdata (info_fifo_rdata),
    .info_fifo_rden  (info_fifo_rden),
    .data_fifo_empty (data_fifo_empty),
    .data_fifo_rdata (data_fifo_rdata),
    .data_fifo_rden  (data_fifo_rden),
    .good_fifo_wdata (good_fifo_wdata),
    .good_fifo_wren  (good_fifo_wren),
    .good_fifo_afull (good_fifo_afull),
    .ctrl_fifo_wdata (ctrl_fifo_wdata),
    .ctrl_fifo_wren  (ctrl_fifo_wren),
    .ctrl_fifo_afull (ctrl_fifo_afull),
    .good_frame_cnt  (good_frame_cnt),
    .drop_frame_cnt  (drop_frame_cnt)
  );

  always #5 s2mm_clk = ~s2mm_clk;

  logic [72:0] dq[$];
  logic [7:0]  iq[$];
  logic [72:0] good_log[$];
  logic [36:0] ctrl_log[$];
  logic        gap = 1'b0;
  logic        take_d = 1'b0;
  logic        take_i = 1'b0;
  int          pops = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_good = 0;
  int          exp_drop = 0;

  task automatic check(input string tag, input logic [72:0] act, input logic [72:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef IFM_RX_SORT_STATS_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic void refresh();
    data_fifo_empty = gap || (dq.size() == 0);
    data_fifo_rdata = (dq.size() != 0) ? dq[0] : '0;
    info_fifo_empty = (iq.size() == 0);
    info_fifo_rdata = (iq.size() != 0) ? iq[0] : '0;
  endfunction

  // FWFT source model: pop after an edge on which the DUT held rden with data available.
  initial begin
    refresh();
    forever begin
      @(posedge s2mm_clk);
      #1;
      if (take_d && dq.size() != 0) begin
        void'(dq.pop_front());
        pops++;
      end
      if (take_i && iq.size() != 0) void'(iq.pop_front());
      refresh();
      @(negedge s2mm_clk);
      refresh();
      #1;
      take_d = data_fifo_rden && !data_fifo_empty;
      take_i = info_fifo_rden && !info_fifo_empty;
    end
  end

  always @(negedge s2mm_clk) begin
    if (!sys_rst) begin
      if (good_fifo_wren) good_log.push_back(good_fifo_wdata);
      if (ctrl_fifo_wren) ctrl_log.push_back(ctrl_fifo_wdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge s2mm_clk);
    #3;
  endtask

  function automatic logic [72:0] word_of(input logic [63:0] base, input int i, input int n,
                                          input logic [7:0] last_keep);
    logic [7:0] k;
    k = (i == n - 1) ? last_keep : 8'hFF;
    return {(i == n - 1), k, base + 64'(i)};
  endfunction

  task automatic push_frame(input logic [7:0] info, input int n, input logic [7:0] last_keep,
                            input logic [63:0] base);
    for (int i = 0; i < n; i++) dq.push_back(word_of(base, i, n, last_keep));
    iq.push_back(info);
  endtask

  task automatic wait_ctrl(input int target);
    for (int c = 0; c < 400 && ctrl_log.size() < target; c++) tick(1);
    tick(1);
    check("ctrl_count", 73'(ctrl_log.size()), 73'(target));
  endtask

  task automatic wait_pops(input int target);
    for (int c = 0; c < 400 && pops < target; c++) tick(1);
    check("pop_reach", 73'(pops >= target), 73'(1));
  endtask

  task automatic check_frame(input string tag, input int gb, input int cb, input int n,
                             input logic [63:0] base, input logic [7:0] last_keep,
                             input logic [7:0] info, input logic [15:0] bytes);
    check({tag, "_good_n"}, 73'(good_log.size() - gb), 73'(n));
    for (int i = 0; i < n; i++)
      check({tag, "_good"}, good_log[gb + i], word_of(base, i, n, last_keep));
    check({tag, "_sts0"}, 73'(ctrl_log[cb]), 73'({1'b0, 4'hF, 4'h5, 20'h0, info}));
    for (int k = 1; k < 5; k++) check({tag, "_sts_mid"}, 73'(ctrl_log[cb + k]), 73'(37'h0F00000000));
    check({tag, "_sts5"}, 73'(ctrl_log[cb + 5]), 73'({1'b1, 4'hF, 16'h0, bytes}));
  endtask

  initial begin
    int g0;
    int c0;
    int p0;
    int p1;
    int n;
    tick(2);
    check("rst_good_wren", 73'(good_fifo_wren), 73'(0));
    check("rst_ctrl_wren", 73'(ctrl_fifo_wren), 73'(0));
    check("rst_good_wdata", good_fifo_wdata, 73'(0));
    check("rst_ctrl_wdata", 73'(ctrl_fifo_wdata), 73'(0));
    check("rst_good_cnt", 73'(good_frame_cnt), 73'(0));
    check("rst_drop_cnt", 73'(drop_frame_cnt), 73'(0));
    check("rst_rden", 73'({info_fifo_rden, data_fifo_rden}), 73'(0));
    sys_rst = 1'b0;
    tick(2);

    // 64-byte good frame
    push_frame(8'h01, 8, 8'hFF, 64'hA000);
    wait_ctrl(6);
    check_frame("f64", 0, 0, 8, 64'hA000, 8'hFF, 8'h01, 16'h0040);
    check("f64_sts0_lit", 73'(ctrl_log[0]), 73'(37'h0F50000001));
    check("f64_sts5_lit", 73'(ctrl_log[5]), 73'(37'h1F00000040));
    exp_good++;
    check("f64_good_cnt", 73'(good_frame_cnt), 73'(cnt_exp(exp_good)));

    // 61-byte good frame
    push_frame(8'h01, 8, 8'h1F, 64'hB000);
    wait_ctrl(12);
    check_frame("f61", 8, 6, 8, 64'hB000, 8'h1F, 8'h01, 16'h003D);
    check("f61_sts5_lit", 73'(ctrl_log[11]), 73'(37'h1F0000003D));
    exp_good++;

    // bad frames: FCS bad, then FCS good with length error
    g0 = good_log.size();
    c0 = ctrl_log.size();
    p0 = pops;
    push_frame(8'h00, 10, 8'hFF, 64'hC000);
    push_frame(8'h03, 3, 8'hFF, 64'hC100);
    for (int c = 0; c < 200 && (dq.size() != 0 || iq.size() != 0); c++) tick(1);
    tick(3);
    check("drop_pops", 73'(pops - p0), 73'(13));
    check("drop_good_n", 73'(good_log.size()), 73'(g0));
    check("drop_ctrl_n", 73'(ctrl_log.size()), 73'(c0));
    exp_drop += 2;
    check("drop_cnt", 73'(drop_frame_cnt), 73'(cnt_exp(exp_drop)));

    // good frame after drops
    push_frame(8'h01, 4, 8'h0F, 64'hD000);
    wait_ctrl(c0 + 6);
    check_frame("after_drop", g0, c0, 4, 64'hD000, 8'h0F, 8'h01, 16'h001C);
    exp_good++;

    // good-FIFO backpressure, then ctrl backpressure on status word 3
    g0 = good_log.size();
    c0 = ctrl_log.size();
    p0 = pops;
    push_frame(8'h01, 8, 8'hFF, 64'hE000);
    wait_pops(p0 + 3);
    good_fifo_afull = 1'b1;
    p1 = pops;
    tick(20);
    check("afull_no_pop", 73'(pops), 73'(p1));
    check("afull_writes", 73'(good_log.size() - g0), 73'(p1 - p0));
    good_fifo_afull = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      tick(1);
      if (ctrl_fifo_wren) n++;
    end
    ctrl_fifo_afull = 1'b1;
    tick(6);
    check("cafull_hold", 73'(ctrl_log.size() - c0), 73'(3));
    ctrl_fifo_afull = 1'b0;
    wait_ctrl(c0 + 6);
    check_frame("bp", g0, c0, 8, 64'hE000, 8'hFF, 8'h01, 16'h0040);
    exp_good++;

    // empty gap mid-frame
    g0 = good_log.size();
    c0 = ctrl_log.size();
    p0 = pops;
    push_frame(8'h01, 8, 8'hFF, 64'hF000);
    wait_pops(p0 + 4);
    gap = 1'b1;
    p1 = pops;
    tick(5);
    check("gap_no_pop", 73'(pops), 73'(p1));
    gap = 1'b0;
    wait_ctrl(c0 + 6);
    check_frame("gap", g0, c0, 8, 64'hF000, 8'hFF, 8'h01, 16'h0040);
    exp_good++;
    check("good_cnt_5", 73'(good_frame_cnt), 73'(cnt_exp(exp_good)));

    // reset mid-frame
    p0 = pops;
    push_frame(8'h01, 8, 8'hFF, 64'h1000);
    wait_pops(p0 + 4);
    sys_rst = 1'b1;
    dq.delete();
    iq.delete();
    #1;
    check("mrst_wren", 73'({good_fifo_wren, ctrl_fifo_wren}), 73'(0));
    check("mrst_good_wdata", good_fifo_wdata, 73'(0));
    check("mrst_ctrl_wdata", 73'(ctrl_fifo_wdata), 73'(0));
    check("mrst_cnts", 73'({drop_frame_cnt, good_frame_cnt}), 73'(0));
    exp_good = 0;
    exp_drop = 0;
    tick(2);
    check("mrst_rden", 73'({info_fifo_rden, data_fifo_rden}), 73'(0));
    sys_rst = 1'b0;
    good_log.delete();
    ctrl_log.delete();
    tick(2);
    push_frame(8'h01, 2, 8'h01, 64'h2000);
    wait_ctrl(6);
    check_frame("post_rst", 0, 0, 2, 64'h2000, 8'h01, 8'h01, 16'h0009);
    exp_good++;
    check("post_rst_good_cnt", 73'(good_frame_cnt), 73'(cnt_exp(exp_good)));
    check("post_rst_drop_cnt", 73'(drop_frame_cnt), 73'(cnt_exp(exp_drop)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
